// File: rtl/ptw_arbiter_if.sv
// Bundle of TLB-miss, walker-request and walker-response signals shared by the
// page-table-walker arbiter (slave side) and its environment (master side).
interface ptw_arbiter_if;
  logic [19:0] itlb_vpn_i;
  logic        itlb_vpn_vld_i;
  logic        itlb_flush_i;
  logic        itlb_resp_vld_o;
  logic        itlb_is_superpage_o;
  logic [31:0] itlb_pte_o;
  logic [3:0]  itlb_excp_code_o;
  logic        itlb_excp_vld_o;

  logic [19:0] dtlb_vpn_i;
  logic        dtlb_vpn_vld_i;
  logic        dtlb_isWrite_i;
  logic        dtlb_flush_i;
  logic        dtlb_resp_vld_o;
  logic        dtlb_is_superpage_o;
  logic [31:0] dtlb_pte_o;
  logic [3:0]  dtlb_excp_code_o;
  logic        dtlb_excp_vld_o;

  logic        sfence_req_i;
  logic        sfence_ok_o;

  logic        ptw_req_o;
  logic [19:0] ptw_vpn_o;
  logic        ptw_isWrite_o;
  logic        ptw_isInstr_o;
  logic        ptw_resp_vld_i;
  logic        ptw_is_superpage_i;
  logic [31:0] ptw_pte_i;
  logic [3:0]  ptw_excp_code_i;
  logic        ptw_excp_vld_i;

  modport slave (
    input  itlb_vpn_i, itlb_vpn_vld_i, itlb_flush_i,
    output itlb_resp_vld_o, itlb_is_superpage_o, itlb_pte_o, itlb_excp_code_o, itlb_excp_vld_o,
    input  dtlb_vpn_i, dtlb_vpn_vld_i, dtlb_isWrite_i, dtlb_flush_i,
    output dtlb_resp_vld_o, dtlb_is_superpage_o, dtlb_pte_o, dtlb_excp_code_o, dtlb_excp_vld_o,
    input  sfence_req_i,
    output sfence_ok_o,
    output ptw_req_o, ptw_vpn_o, ptw_isWrite_o, ptw_isInstr_o,
    input  ptw_resp_vld_i, ptw_is_superpage_i, ptw_pte_i, ptw_excp_code_i, ptw_excp_vld_i
  );

  modport master (
    output itlb_vpn_i, itlb_vpn_vld_i, itlb_flush_i,
    input  itlb_resp_vld_o, itlb_is_superpage_o, itlb_pte_o, itlb_excp_code_o, itlb_excp_vld_o,
    output dtlb_vpn_i, dtlb_vpn_vld_i, dtlb_isWrite_i, dtlb_flush_i,
    input  dtlb_resp_vld_o, dtlb_is_superpage_o, dtlb_pte_o, dtlb_excp_code_o, dtlb_excp_vld_o,
    output sfence_req_i,
    input  sfence_ok_o,
    input  ptw_req_o, ptw_vpn_o, ptw_isWrite_o, ptw_isInstr_o,
    output ptw_resp_vld_i, ptw_is_superpage_i, ptw_pte_i, ptw_excp_code_i, ptw_excp_vld_i
  );
endinterface

// File: rtl/ptw_arbiter.sv
// Shares one hardware page-table walker between the ITLB and DTLB: grants one
// miss at a time and steers the walker response back to its owner only.
module ptw_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic cpu_clk_i,
  input  logic cpu_rst_i,
  ptw_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_COOL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_dtlb_q;
  logic        last_dtlb_q;
  logic        kill_q;
  logic [19:0] vpn_q;
  logic        is_write_q;
  logic        is_instr_q;

  logic        itlb_elig, dtlb_elig;
  logic        grant, grant_dtlb;
  logic        owner_flush;
  logic        resp_ok;

  assign itlb_elig   = bus.itlb_vpn_vld_i & ~bus.itlb_flush_i;
  assign dtlb_elig   = bus.dtlb_vpn_vld_i & ~bus.dtlb_flush_i;
  assign owner_flush = owner_dtlb_q ? bus.dtlb_flush_i : bus.itlb_flush_i;

  // Grants happen only in IDLE and are held off by a pending sfence; on a tie
  // round-robin picks whoever did not win last, fixed priority always picks DTLB.
  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_dtlb = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.sfence_req_i && (itlb_elig || dtlb_elig)) begin
          grant = 1'b1;
          if (itlb_elig && dtlb_elig)
            grant_dtlb = RR_EN ? ~last_dtlb_q : 1'b1;
          else
            grant_dtlb = dtlb_elig;
          state_d = ST_WALK;
        end
      end
      ST_WALK: begin
        if (bus.ptw_resp_vld_i)
          state_d = ST_COOL;
      end
      ST_COOL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Request context is frozen at grant time so the walker sees stable inputs;
  // kill remembers an owner flush seen at any point during the walk.
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      owner_dtlb_q <= 1'b0;
      last_dtlb_q  <= 1'b0;
      kill_q       <= 1'b0;
      vpn_q        <= '0;
      is_write_q   <= 1'b0;
      is_instr_q   <= 1'b0;
    end else if (grant) begin
      owner_dtlb_q <= grant_dtlb;
      last_dtlb_q  <= grant_dtlb;
      kill_q       <= 1'b0;
      vpn_q        <= grant_dtlb ? bus.dtlb_vpn_i : bus.itlb_vpn_i;
      is_write_q   <= grant_dtlb & bus.dtlb_isWrite_i;
      is_instr_q   <= ~grant_dtlb;
    end else if (state_q == ST_WALK && owner_flush) begin
      kill_q <= 1'b1;
    end
  end

  assign resp_ok = (state_q == ST_WALK) & bus.ptw_resp_vld_i & ~kill_q & ~owner_flush;

  assign bus.ptw_req_o     = (state_q == ST_WALK);
  assign bus.ptw_vpn_o     = vpn_q;
  assign bus.ptw_isWrite_o = is_write_q;
  assign bus.ptw_isInstr_o = is_instr_q;
  assign bus.sfence_ok_o   = bus.sfence_req_i & (state_q == ST_IDLE);

  // Data buses mirror the walker to both TLBs; only the strobe is owner-qualified.
  assign bus.itlb_resp_vld_o     = resp_ok & ~owner_dtlb_q;
  assign bus.itlb_is_superpage_o = bus.ptw_is_superpage_i;
  assign bus.itlb_pte_o          = bus.ptw_pte_i;
  assign bus.itlb_excp_code_o    = bus.ptw_excp_code_i;
  assign bus.itlb_excp_vld_o     = bus.ptw_excp_vld_i;

  assign bus.dtlb_resp_vld_o     = resp_ok & owner_dtlb_q;
  assign bus.dtlb_is_superpage_o = bus.ptw_is_superpage_i;
  assign bus.dtlb_pte_o          = bus.ptw_pte_i;
  assign bus.dtlb_excp_code_o    = bus.ptw_excp_code_i;
  assign bus.dtlb_excp_vld_o     = bus.ptw_excp_vld_i;

endmodule

// File: doc/ptw_arbiter.md
# ptw_arbiter

Shares the single hardware page-table walker (HPW) between the instruction TLB and the data TLB. It accepts level-held miss requests (VPN plus valid) from both TLBs and grants one at a time, round-robin or DTLB-first. It forwards the granted VPN to the walker and routes the walker's PTE or exception response back to the owner only. It also discards responses whose owner was flushed mid-walk and quiesces the walker for sfence.

## Interface
- RR_EN, default 1: 1 = round-robin on simultaneous requests; 0 = fixed priority, DTLB always wins.
- cpu_clk_i  in  1  core clock; all state changes on its rising edge.
- cpu_rst_i  in  1  synchronous, active-high reset.
- itlb_vpn_i  in  20  ITLB miss VPN.
- itlb_vpn_vld_i  in  1  ITLB request; held until the cycle after its response.
- itlb_flush_i  in  1  kills any ITLB request or walk in flight.
- itlb_resp_vld_o  out  1  response strobe to ITLB.
- itlb_is_superpage_o  out  1  superpage flag to ITLB.
- itlb_pte_o  out  32  PTE to ITLB.
- itlb_excp_code_o  out  4  exception code to ITLB.
- itlb_excp_vld_o  out  1  exception valid to ITLB.
- dtlb_vpn_i  in  20  DTLB miss VPN.
- dtlb_vpn_vld_i  in  1  DTLB request; same holding rule as ITLB.
- dtlb_isWrite_i  in  1  DTLB access is a store.
- dtlb_flush_i  in  1  kills any DTLB request or walk in flight.
- dtlb_resp_vld_o, dtlb_is_superpage_o, dtlb_pte_o[31:0], dtlb_excp_code_o[3:0], dtlb_excp_vld_o  out  DTLB response bundle; same widths and meanings as the ITLB bundle.
- sfence_req_i  in  1  sfence pending; blocks new grants while high.
- sfence_ok_o  out  1  walker idle and no grant in progress.
- ptw_req_o  out  1  request to walker; held high until the response cycle.
- ptw_vpn_o  out  20  granted VPN.
- ptw_isWrite_o  out  1  store access; forced 0 for ITLB grants.
- ptw_isInstr_o  out  1  1 = ITLB grant; the walker uses it to select fault code 12, 13 or 15.
- ptw_resp_vld_i, ptw_is_superpage_i, ptw_pte_i[31:0], ptw_excp_code_i[3:0], ptw_excp_vld_i  in  walker response bundle.

## Operation
- The controller has three states:
  - IDLE: no walk outstanding; grants are made here.
  - WALK: a request is outstanding at the walker.
  - COOL: one idle cycle after each response.
- Eligibility:
  - ITLB is eligible when itlb_vpn_vld_i & !itlb_flush_i.
  - DTLB is eligible when dtlb_vpn_vld_i & !dtlb_flush_i.
- Grant (IDLE only, and only when sfence_req_i=0):
  - One eligible requester: grant it.
  - Both eligible with RR_EN=1: grant the requester not in last_grant.
  - Both eligible with RR_EN=0: grant DTLB.
- On grant, latch owner, VPN, isWrite (ANDed with DTLB ownership) and isInstr; update last_grant; clear kill; move to WALK.
- WALK:
  - ptw_req_o=1 and ptw_vpn_o/isWrite/isInstr are stable.
  - kill is set if the owner's flush is asserted in any WALK cycle, including the response cycle.
- Response (ptw_resp_vld_i in WALK):
  - The owner's resp_vld_o equals ptw_resp_vld_i & !kill & !owner_flush, combinationally in the same cycle.
  - The PTE, superpage, code and exception fields pass through unchanged to the owner.
  - The non-owner's resp_vld_o stays 0. Both data buses may carry walker data, but consumers qualify them with resp_vld.
  - Next state is COOL.
- COOL: no grant is made; next state is IDLE. This absorbs the requester's registered deassertion of vpn_vld, so the same miss is never walked twice.
- ptw_resp_vld_i outside WALK is ignored.
- sfence_ok_o = sfence_req_i & (state==IDLE). When sfence and a request arrive in the same IDLE cycle, sfence wins and no grant is made.
- Flush arriving in IDLE simply makes that requester ineligible; no state is kept.

## Timing
- Reset values:
  - State IDLE, ptw_req_o=0, ptw_vpn_o=0, ptw_isWrite_o=0, ptw_isInstr_o=0.
  - kill=0; last_grant=ITLB, so DTLB wins the first tie.
  - All resp_vld_o=0 and sfence_ok_o=0.
- Reset mid-walk returns to IDLE next cycle. A walker response during or after reset is ignored until a new grant.
- Request visible in IDLE at cycle N: ptw_req_o=1 from N+1.
- Walker response at cycle M:
  - Owner strobe at M.
  - ptw_req_o=0 at M+1 (COOL).
  - IDLE at M+2; the earliest next grant is at M+2 and the next ptw_req_o at M+3.
- Minimum request-to-response latency through the block is 1 cycle plus walker latency.
- Back-to-back walks alternate I/D under continuous contention with RR_EN=1.

## Test plan
- ITLB only, vpn 0x12345; walker responds 4 cycles after ptw_req_o with pte 0x2000_0C0F -> ptw_vpn_o=0x12345 and ptw_isInstr_o=1 one cycle after the request; itlb_resp_vld_o=1 for exactly one cycle carrying pte 0x2000_0C0F; dtlb_resp_vld_o stays 0.
- Both request continuously, RR_EN=1, out of reset -> grant order D, I, D, I; grants separated by the COOL cycle; ptw_isWrite_o follows dtlb_isWrite_i only on D grants.
- RR_EN=0, both request continuously -> DTLB granted for each of 3 consecutive walks; ITLB never granted.
- DTLB walk in flight and dtlb_flush_i pulsed 2 cycles before the walker response -> dtlb_resp_vld_o stays 0; state goes to COOL then IDLE; a new ITLB request is granted afterward.
- sfence_req_i raised during a walk with an ITLB request pending -> sfence_ok_o=0 until IDLE, then 1; no grant while sfence_req_i is high; ITLB granted the cycle after sfence_req_i drops.
- cpu_rst_i asserted for one cycle mid-walk; walker responds afterward -> both resp_vld_o stay 0; ptw_req_o=0 the cycle after reset.
